// File: rtl/rob_retire_pkg.sv
// rob_retire_pkg
//   Shared sizing constants for the reorder buffer / retire stage.
//   Physical register aliases are PR_ADDR_W bits; each ROB entry carries two
//   old aliases (ALIAS_W bits) plus an ARCH_MASK_W architectural dest mask.
//   Alias values 0 and 1 are architectural-zero placeholders; the ROB never
//   interprets aliases, it only carries them to the free-list bus.
package rob_retire_pkg;
  localparam int PR_ADDR_W    = 5;
  localparam int ALIAS_W      = 2 * PR_ADDR_W;
  localparam int ARCH_MASK_W  = 8;
  localparam int ROB_DEPTH    = 32;
  localparam int ROB_WIDTH    = 4;
  localparam int ROB_CMPL_W   = 6;
  localparam int ROB_RETIRE_W = 3;
endpackage

// File: rtl/rob_retire_select.sv
// rob_retire_select
//   Combinational retire picker. Walks entries starting at head and counts
//   how many consecutive ones are both valid and done, capped at RETIRE_W
//   and at the live entry count.
// Ports:
//   valid_i, done_i : per-entry status vectors
//   head_i          : oldest entry index
//   count_i         : number of live entries (0..DEPTH)
//   n_o             : number of entries to retire this cycle
//   slot_idx_o      : ROB index for each retire slot (head + s)
module rob_retire_select
  import rob_retire_pkg::*;
#(
  parameter int DEPTH    = ROB_DEPTH,
  parameter int RETIRE_W = ROB_RETIRE_W,
  localparam int IDX_W   = $clog2(DEPTH),
  localparam int CNT_W   = IDX_W + 1,
  localparam int N_W     = $clog2(RETIRE_W + 1)
) (
  input  logic [DEPTH-1:0]                valid_i,
  input  logic [DEPTH-1:0]                done_i,
  input  logic [IDX_W-1:0]                head_i,
  input  logic [CNT_W-1:0]                count_i,
  output logic [N_W-1:0]                  n_o,
  output logic [RETIRE_W-1:0][IDX_W-1:0]  slot_idx_o
);

  always_comb begin
    logic run;
    run = 1'b1;
    n_o = '0;
    for (int s = 0; s < RETIRE_W; s++) begin
      slot_idx_o[s] = head_i + IDX_W'(s);
      // Retirement stops at the first entry that is not ready: in-order only.
      if (run && valid_i[slot_idx_o[s]] && done_i[slot_idx_o[s]] &&
          (CNT_W'(s) < count_i)) begin
        n_o = N_W'(s + 1);
      end else begin
        run = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rob_retire.sv
// rob_retire
//   Reorder buffer with in-order retirement. Hands out WIDTH consecutive ROB
//   indices per dispatch group, records old aliases and arch masks, marks
//   entries done from CMPL_W completion ports, and retires up to RETIRE_W
//   oldest done entries per cycle. Retire outputs are registered.
// Optional feature: define ROB_PERF_CNT_EN to add retired_count and
//   full_stall_count (32-bit) performance counters.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   alloc_valid       : dispatch group offered (fires when alloc_ready)
//   alloc_ready       : at least WIDTH free entries
//   alloc_entries     : indices tail..tail+WIDTH-1, lane 0 in LSBs
//   alloc_old_aliases : per lane two old physical regs
//   alloc_arch_regs   : per lane architectural destination mask
//   cmplt_valid       : per-port completion strobe
//   cmplt_rob_idx     : per-port completed ROB index
//   free_regs         : old aliases of retired ops, slot 0 oldest, 0 if idle
//   retire_valid      : per-slot retire strobe, thermometer from slot 0
//   retire_arch_regs  : arch mask of each retired op
module rob_retire
  import rob_retire_pkg::*;
#(
  parameter int DEPTH    = ROB_DEPTH,
  parameter int WIDTH    = ROB_WIDTH,
  parameter int CMPL_W   = ROB_CMPL_W,
  parameter int RETIRE_W = ROB_RETIRE_W,
  localparam int IDX_W   = $clog2(DEPTH),
  localparam int CNT_W   = IDX_W + 1,
  localparam int N_W     = $clog2(RETIRE_W + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          alloc_valid,
  output logic                          alloc_ready,
  output logic [IDX_W*WIDTH-1:0]        alloc_entries,
  input  logic [ALIAS_W*WIDTH-1:0]      alloc_old_aliases,
  input  logic [ARCH_MASK_W*WIDTH-1:0]  alloc_arch_regs,
  input  logic [CMPL_W-1:0]             cmplt_valid,
  input  logic [IDX_W*CMPL_W-1:0]       cmplt_rob_idx,
  output logic [ALIAS_W*RETIRE_W-1:0]   free_regs,
  output logic [RETIRE_W-1:0]           retire_valid,
  output logic [ARCH_MASK_W*RETIRE_W-1:0] retire_arch_regs
`ifdef ROB_PERF_CNT_EN
  ,
  output logic [31:0]                   retired_count,
  output logic [31:0]                   full_stall_count
`endif
);

  logic [IDX_W-1:0]       head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [DEPTH-1:0]       valid_q, valid_d, done_q, done_d;
  logic [ALIAS_W-1:0]     alias_q [DEPTH];
  logic [ARCH_MASK_W-1:0] arch_q  [DEPTH];

  logic [ALIAS_W*RETIRE_W-1:0]     free_regs_q, free_regs_d;
  logic [RETIRE_W-1:0]             retire_valid_q, retire_valid_d;
  logic [ARCH_MASK_W*RETIRE_W-1:0] retire_arch_q, retire_arch_d;

  logic                          alloc_fire;
  logic [N_W-1:0]                sel_n;
  logic [RETIRE_W-1:0][IDX_W-1:0] sel_idx;

  // Ready depends only on registered occupancy, never on this cycle's retire.
  assign alloc_ready = (CNT_W'(DEPTH) - count_q) >= CNT_W'(WIDTH);
  assign alloc_fire  = alloc_valid & alloc_ready;

  always_comb begin
    alloc_entries = '0;
    for (int l = 0; l < WIDTH; l++) begin
      alloc_entries[l*IDX_W +: IDX_W] = tail_q + IDX_W'(l);
    end
  end

  rob_retire_select #(
    .DEPTH    (DEPTH),
    .RETIRE_W (RETIRE_W)
  ) u_select (
    .valid_i    (valid_q),
    .done_i     (done_q),
    .head_i     (head_q),
    .count_i    (count_q),
    .n_o        (sel_n),
    .slot_idx_o (sel_idx)
  );

  // Update order matters: completions, then retire clears, then allocation
  // writes, so an allocation always leaves its entries not-done.
  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    for (int p = 0; p < CMPL_W; p++) begin
      if (cmplt_valid[p] && valid_q[cmplt_rob_idx[p*IDX_W +: IDX_W]]) begin
        done_d[cmplt_rob_idx[p*IDX_W +: IDX_W]] = 1'b1;
      end
    end
    for (int s = 0; s < RETIRE_W; s++) begin
      if (s < int'(sel_n)) begin
        valid_d[sel_idx[s]] = 1'b0;
        done_d[sel_idx[s]]  = 1'b0;
      end
    end
    if (alloc_fire) begin
      for (int l = 0; l < WIDTH; l++) begin
        valid_d[tail_q + IDX_W'(l)] = 1'b1;
        done_d[tail_q + IDX_W'(l)]  = 1'b0;
      end
    end
    head_d  = head_q + IDX_W'(sel_n);
    tail_d  = alloc_fire ? tail_q + IDX_W'(WIDTH) : tail_q;
    count_d = count_q + (alloc_fire ? CNT_W'(WIDTH) : CNT_W'(0)) - CNT_W'(sel_n);
  end

  always_comb begin
    free_regs_d    = '0;
    retire_valid_d = '0;
    retire_arch_d  = '0;
    for (int s = 0; s < RETIRE_W; s++) begin
      if (s < int'(sel_n)) begin
        retire_valid_d[s]                          = 1'b1;
        free_regs_d[s*ALIAS_W +: ALIAS_W]          = alias_q[sel_idx[s]];
        retire_arch_d[s*ARCH_MASK_W +: ARCH_MASK_W] = arch_q[sel_idx[s]];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      valid_q        <= '0;
      done_q         <= '0;
      free_regs_q    <= '0;
      retire_valid_q <= '0;
      retire_arch_q  <= '0;
    end else begin
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      valid_q        <= valid_d;
      done_q         <= done_d;
      free_regs_q    <= free_regs_d;
      retire_valid_q <= retire_valid_d;
      retire_arch_q  <= retire_arch_d;
    end
  end

  // Payload storage needs no reset: it is only read behind valid.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      for (int l = 0; l < WIDTH; l++) begin
        alias_q[tail_q + IDX_W'(l)] <= alloc_old_aliases[l*ALIAS_W +: ALIAS_W];
        arch_q[tail_q + IDX_W'(l)]  <= alloc_arch_regs[l*ARCH_MASK_W +: ARCH_MASK_W];
      end
    end
  end

  assign free_regs        = free_regs_q;
  assign retire_valid     = retire_valid_q;
  assign retire_arch_regs = retire_arch_q;

`ifdef ROB_PERF_CNT_EN
  logic [31:0] retired_cnt_q, stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_cnt_q <= '0;
      stall_cnt_q   <= '0;
    end else begin
      retired_cnt_q <= retired_cnt_q + 32'(sel_n);
      if (alloc_valid && !alloc_ready) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign retired_count    = retired_cnt_q;
  assign full_stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_rob_retire.sv
// tb_rob_retire
//   Self-checking bench for rob_retire. A program-order queue of live ops is
//   the reference: retire takes the oldest done ops (up to 3) each cycle.
module tb_rob_retire;
  localparam int DEPTH = 32, WIDTH = 4, CMPL_W = 6, RETIRE_W = 3;
  localparam int IDX_W = 5, AL_W = 10, AR_W = 8;

  logic clk = 1'b0;
  logic rst;
  logic alloc_valid, alloc_ready;
  logic [IDX_W*WIDTH-1:0] alloc_entries;
  logic [AL_W*WIDTH-1:0] alloc_old_aliases;
  logic [AR_W*WIDTH-1:0] alloc_arch_regs;
  logic [CMPL_W-1:0] cmplt_valid;
  logic [IDX_W*CMPL_W-1:0] cmplt_rob_idx;
  logic [AL_W*RETIRE_W-1:0] free_regs;
  logic [RETIRE_W-1:0] retire_valid;
  logic [AR_W*RETIRE_W-1:0] retire_arch_regs;
`ifdef ROB_PERF_CNT_EN
  logic [31:0] retired_count, full_stall_count;
`endif

  rob_retire dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_entries(alloc_entries),
    .alloc_old_aliases(alloc_old_aliases), .alloc_arch_regs(alloc_arch_regs),
    .cmplt_valid(cmplt_valid), .cmplt_rob_idx(cmplt_rob_idx),
    .free_regs(free_regs), .retire_valid(retire_valid),
    .retire_arch_regs(retire_arch_regs)
`ifdef ROB_PERF_CNT_EN
    , .retired_count(retired_count), .full_stall_count(full_stall_count)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic [IDX_W-1:0] idx;
    logic [AL_W-1:0]  al;
    logic [AR_W-1:0]  ar;
    bit               done;
  } ent_t;

  ent_t exp_q[$];
  int   mdl_tail;
  int   checks, errors;

  // staged stimulus for the next cycle
  logic st_av;
  logic [AL_W*WIDTH-1:0] st_al;
  logic [AR_W*WIDTH-1:0] st_ar;
  logic [CMPL_W-1:0] st_cv;
  logic [IDX_W*CMPL_W-1:0] st_ci;

  // expected and sampled values for the last cycle
  logic exp_ready, act_ready;
  logic [IDX_W*WIDTH-1:0] exp_entries, act_entries;
  logic [RETIRE_W-1:0] exp_rv;
  logic [AL_W*RETIRE_W-1:0] exp_free;
  logic [AR_W*RETIRE_W-1:0] exp_arch;

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    st_av = 1'b0; st_al = '0; st_ar = '0; st_cv = '0; st_ci = '0;
  endtask

  task automatic set_random_group();
    st_av = 1'b1;
    for (int l = 0; l < WIDTH; l++) begin
      st_al[l*AL_W +: AL_W] = AL_W'($urandom_range(0, 1023));
      st_ar[l*AR_W +: AR_W] = AR_W'($urandom_range(0, 255));
    end
  endtask

  // One clock: apply stimulus, sample combinational outputs, advance the
  // model, then step past the edge so registered outputs are visible.
  task automatic drive_cycle();
    int n;
    @(negedge clk);
    alloc_valid = st_av; alloc_old_aliases = st_al; alloc_arch_regs = st_ar;
    cmplt_valid = st_cv; cmplt_rob_idx = st_ci;
    #1;
    act_ready   = alloc_ready;
    act_entries = alloc_entries;
    exp_ready   = (DEPTH - exp_q.size()) >= WIDTH;
    for (int l = 0; l < WIDTH; l++)
      exp_entries[l*IDX_W +: IDX_W] = IDX_W'((mdl_tail + l) % DEPTH);
    n = 0;
    while (n < RETIRE_W && n < exp_q.size() && exp_q[n].done) n++;
    exp_rv = '0; exp_free = '0; exp_arch = '0;
    for (int s = 0; s < n; s++) begin
      exp_rv[s] = 1'b1;
      exp_free[s*AL_W +: AL_W] = exp_q[s].al;
      exp_arch[s*AR_W +: AR_W] = exp_q[s].ar;
    end
    repeat (n) void'(exp_q.pop_front());
    for (int p = 0; p < CMPL_W; p++)
      if (st_cv[p])
        foreach (exp_q[i])
          if (exp_q[i].idx == st_ci[p*IDX_W +: IDX_W]) exp_q[i].done = 1'b1;
    if (st_av && exp_ready) begin
      for (int l = 0; l < WIDTH; l++)
        exp_q.push_back('{IDX_W'((mdl_tail + l) % DEPTH), st_al[l*AL_W +: AL_W],
                          st_ar[l*AR_W +: AR_W], 1'b0});
      mdl_tail = (mdl_tail + WIDTH) % DEPTH;
    end
    @(posedge clk);
    #1;
  endtask

  // Complete every outstanding op until the ROB is empty (bounded).
  task automatic drain();
    string tag = "drain";
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      int k;
      set_idle();
      k = 0;
      foreach (exp_q[i])
        if (!exp_q[i].done && k < CMPL_W) begin
          st_cv[k] = 1'b1; st_ci[k*IDX_W +: IDX_W] = exp_q[i].idx; k++;
        end
      drive_cycle();
      checks++; if (act_ready !== exp_ready) begin errors++; $display("FAIL %s alloc_ready: got %b expected %b", tag, act_ready, exp_ready); end
      checks++; if (retire_valid !== exp_rv) begin errors++; $display("FAIL %s retire_valid: got %b expected %b", tag, retire_valid, exp_rv); end
      checks++; if (free_regs !== exp_free) begin errors++; $display("FAIL %s free_regs: got %h expected %h", tag, free_regs, exp_free); end
      checks++; if (retire_arch_regs !== exp_arch) begin errors++; $display("FAIL %s retire_arch_regs: got %h expected %h", tag, retire_arch_regs, exp_arch); end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL drain timeout: %0d ops left, expected 0", exp_q.size()); end
    set_idle();
    drive_cycle();
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    set_idle();
    alloc_valid = 0; alloc_old_aliases = '0; alloc_arch_regs = '0;
    cmplt_valid = '0; cmplt_rob_idx = '0;
    rst = 1'b1;
    #1;
    exp_q.delete(); mdl_tail = 0;
    checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL reset alloc_ready: got %b expected 1", alloc_ready); end
    checks++; if (alloc_entries !== {5'd3, 5'd2, 5'd1, 5'd0}) begin errors++; $display("FAIL reset alloc_entries: got %h expected %h", alloc_entries, {5'd3, 5'd2, 5'd1, 5'd0}); end
    checks++; if (retire_valid !== 3'b000) begin errors++; $display("FAIL reset retire_valid: got %b expected 000", retire_valid); end
    checks++; if (free_regs !== 30'd0) begin errors++; $display("FAIL reset free_regs: got %h expected 0", free_regs); end
    checks++; if (retire_arch_regs !== 24'd0) begin errors++; $display("FAIL reset retire_arch_regs: got %h expected 0", retire_arch_regs); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic_retire();
    string tag = "basic";
    logic [AL_W*RETIRE_W-1:0] want;
    want = {5'd9, 5'd10, 5'd7, 5'd0, 5'd5, 5'd6};
    for (int k = 0; k < 4; k++) begin
      set_idle();
      if (k == 0) begin
        set_random_group();
        st_al = {5'd11, 5'd12, 5'd9, 5'd10, 5'd7, 5'd0, 5'd5, 5'd6};
      end
      if (k == 1) begin st_cv = 6'b000111; st_ci[14:0] = {5'd2, 5'd1, 5'd0}; end
      drive_cycle();
      checks++; if (act_ready !== exp_ready) begin errors++; $display("FAIL %s alloc_ready: got %b expected %b", tag, act_ready, exp_ready); end
      checks++; if (act_entries !== exp_entries) begin errors++; $display("FAIL %s alloc_entries: got %h expected %h", tag, act_entries, exp_entries); end
      checks++; if (retire_valid !== exp_rv) begin errors++; $display("FAIL %s retire_valid: got %b expected %b", tag, retire_valid, exp_rv); end
      checks++; if (free_regs !== exp_free) begin errors++; $display("FAIL %s free_regs: got %h expected %h", tag, free_regs, exp_free); end
      checks++; if (retire_arch_regs !== exp_arch) begin errors++; $display("FAIL %s retire_arch_regs: got %h expected %h", tag, retire_arch_regs, exp_arch); end
      if (k == 2) begin
        checks++; if (retire_valid !== 3'b111 || free_regs !== want) begin errors++; $display("FAIL basic first_retire: got %b/%h expected 111/%h", retire_valid, free_regs, want); end
      end
      if (k == 3) begin
        checks++; if (retire_valid !== 3'b000) begin errors++; $display("FAIL basic idx3_waits: got %b expected 000", retire_valid); end
      end
    end
    drain();
  endtask

  task automatic test_out_of_order();
    string tag = "ooo";
    logic [IDX_W-1:0] base;
    base = IDX_W'(mdl_tail);
    for (int k = 0; k < 6; k++) begin
      set_idle();
      if (k == 0) set_random_group();
      if (k == 1) begin st_cv = 6'b000011; st_ci[9:0] = {base + 5'd2, base + 5'd1}; end
      if (k == 3) begin st_cv = 6'b000001; st_ci[4:0] = base; end
      drive_cycle();
      checks++; if (act_ready !== exp_ready) begin errors++; $display("FAIL %s alloc_ready: got %b expected %b", tag, act_ready, exp_ready); end
      checks++; if (act_entries !== exp_entries) begin errors++; $display("FAIL %s alloc_entries: got %h expected %h", tag, act_entries, exp_entries); end
      checks++; if (retire_valid !== exp_rv) begin errors++; $display("FAIL %s retire_valid: got %b expected %b", tag, retire_valid, exp_rv); end
      checks++; if (free_regs !== exp_free) begin errors++; $display("FAIL %s free_regs: got %h expected %h", tag, free_regs, exp_free); end
      checks++; if (retire_arch_regs !== exp_arch) begin errors++; $display("FAIL %s retire_arch_regs: got %h expected %h", tag, retire_arch_regs, exp_arch); end
    end
    drain();
  endtask

  task automatic test_unallocated_complete();
    string tag = "unalloc";
    for (int k = 0; k < 5; k++) begin
      set_idle();
      st_cv = 6'b001001;
      st_ci[4:0] = 5'd20; st_ci[19:15] = IDX_W'(mdl_tail + 1);
      if (k == 1) set_random_group();
      drive_cycle();
      checks++; if (act_ready !== exp_ready) begin errors++; $display("FAIL %s alloc_ready: got %b expected %b", tag, act_ready, exp_ready); end
      checks++; if (act_entries !== exp_entries) begin errors++; $display("FAIL %s alloc_entries: got %h expected %h", tag, act_entries, exp_entries); end
      checks++; if (retire_valid !== exp_rv) begin errors++; $display("FAIL %s retire_valid: got %b expected %b", tag, retire_valid, exp_rv); end
      checks++; if (free_regs !== exp_free) begin errors++; $display("FAIL %s free_regs: got %h expected %h", tag, free_regs, exp_free); end
    end
    drain();
  endtask

  task automatic test_full();
    string tag = "full";
    for (int k = 0; k < 16; k++) begin
      set_idle();
      set_random_group();
      if (k >= 9 && exp_q.size() > 0) begin st_cv = 6'b000001; st_ci[4:0] = exp_q[0].idx; end
      drive_cycle();
      checks++; if (act_ready !== exp_ready) begin errors++; $display("FAIL %s alloc_ready: got %b expected %b", tag, act_ready, exp_ready); end
      checks++; if (act_entries !== exp_entries) begin errors++; $display("FAIL %s alloc_entries: got %h expected %h", tag, act_entries, exp_entries); end
      checks++; if (retire_valid !== exp_rv) begin errors++; $display("FAIL %s retire_valid: got %b expected %b", tag, retire_valid, exp_rv); end
      checks++; if (free_regs !== exp_free) begin errors++; $display("FAIL %s free_regs: got %h expected %h", tag, free_regs, exp_free); end
      if (k == 7) begin
        checks++; if (act_ready !== 1'b1) begin errors++; $display("FAIL full ready_at_28: got %b expected 1", act_ready); end
      end
      if (k == 8) begin
        checks++; if (act_ready !== 1'b0) begin errors++; $display("FAIL full ready_at_32: got %b expected 0", act_ready); end
      end
    end
    drain();
  endtask

  task automatic test_random();
    string tag = "rand";
    for (int k = 0; k < 400; k++) begin
      set_idle();
      if ($urandom_range(0, 1) == 1) set_random_group();
      for (int p = 0; p < CMPL_W; p++) begin
        st_cv[p] = ($urandom_range(0, 1) == 1);
        if (exp_q.size() > 0 && $urandom_range(0, 3) != 0)
          st_ci[p*IDX_W +: IDX_W] = exp_q[$urandom_range(0, exp_q.size() - 1)].idx;
        else
          st_ci[p*IDX_W +: IDX_W] = IDX_W'($urandom_range(0, DEPTH - 1));
      end
      drive_cycle();
      checks++; if (act_ready !== exp_ready) begin errors++; $display("FAIL %s alloc_ready: got %b expected %b", tag, act_ready, exp_ready); end
      checks++; if (act_entries !== exp_entries) begin errors++; $display("FAIL %s alloc_entries: got %h expected %h", tag, act_entries, exp_entries); end
      checks++; if (retire_valid !== exp_rv) begin errors++; $display("FAIL %s retire_valid: got %b expected %b", tag, retire_valid, exp_rv); end
      checks++; if (free_regs !== exp_free) begin errors++; $display("FAIL %s free_regs: got %h expected %h", tag, free_regs, exp_free); end
      checks++; if (retire_arch_regs !== exp_arch) begin errors++; $display("FAIL %s retire_arch_regs: got %h expected %h", tag, retire_arch_regs, exp_arch); end
    end
    drain();
  endtask

  task automatic test_reset_mid();
    string tag = "rstmid";
    for (int k = 0; k < 5; k++) begin
      set_idle();
      if (k < 3) set_random_group();
      if (k == 3) begin st_cv = 6'b000011; st_ci[9:0] = {exp_q[1].idx, exp_q[0].idx}; end
      drive_cycle();
      checks++; if (retire_valid !== exp_rv) begin errors++; $display("FAIL %s retire_valid: got %b expected %b", tag, retire_valid, exp_rv); end
      checks++; if (free_regs !== exp_free) begin errors++; $display("FAIL %s free_regs: got %h expected %h", tag, free_regs, exp_free); end
    end
    checks++; if (exp_q.size() != 10) begin errors++; $display("FAIL rstmid live_before_reset: got %0d expected 10", exp_q.size()); end
    rst = 1'b1;
    #1;
    checks++; if (retire_valid !== 3'b000) begin errors++; $display("FAIL rstmid retire_valid: got %b expected 000", retire_valid); end
    checks++; if (free_regs !== 30'd0) begin errors++; $display("FAIL rstmid free_regs: got %h expected 0", free_regs); end
    checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL rstmid alloc_ready: got %b expected 1", alloc_ready); end
    checks++; if (alloc_entries !== {5'd3, 5'd2, 5'd1, 5'd0}) begin errors++; $display("FAIL rstmid alloc_entries: got %h expected %h", alloc_entries, {5'd3, 5'd2, 5'd1, 5'd0}); end
    exp_q.delete(); mdl_tail = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      set_idle();
      if (k == 0) set_random_group();
      if (k == 1) begin st_cv = 6'b001111; st_ci[19:0] = {5'd3, 5'd2, 5'd1, 5'd0}; end
      drive_cycle();
      checks++; if (act_entries !== exp_entries) begin errors++; $display("FAIL %s post alloc_entries: got %h expected %h", tag, act_entries, exp_entries); end
      checks++; if (retire_valid !== exp_rv) begin errors++; $display("FAIL %s post retire_valid: got %b expected %b", tag, retire_valid, exp_rv); end
      checks++; if (free_regs !== exp_free) begin errors++; $display("FAIL %s post free_regs: got %h expected %h", tag, free_regs, exp_free); end
    end
    drain();
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    checks = 0; errors = 0;
    test_reset();
    test_basic_retire();
    test_out_of_order();
    test_unallocated_complete();
    test_full();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
